// File: rtl/sincos_cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sincos_cordic_pkg
//  Purpose  : Shared types and constants for the sin/cos CORDIC engine.
//             Holds the FSM state type, the arctangent table and the
//             CORDIC gain constant.
//  Revision : 1.0 - initial release
// ============================================================================
package sincos_cordic_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Phase accumulator width; one LSB is 2^-24 of a full turn
  localparam int PHASE_W      = 24;
  // Iteration index width, enough for the 20-entry arctangent table
  localparam int IDX_W        = 5;
  localparam int ATAN_ENTRIES = 20;
  // Extra fractional guard bits carried on x/y during rotation
  localparam int FRAC_EXT     = 8;

  // Inverse of the accumulated CORDIC gain; pre-scaling x by this makes the
  // final vector length exactly 1.0 in the output format
  localparam real CORDIC_GAIN = 0.6072529350;

  // atan(2^-idx) expressed in 2^-24 turn units, rounded to nearest
  function automatic logic [PHASE_W-1:0] atan_lut(input logic [IDX_W-1:0] idx);
    logic [PHASE_W-1:0] v;
    case (idx)
      5'd0:    v = 24'd2097152;
      5'd1:    v = 24'd1238021;
      5'd2:    v = 24'd654136;
      5'd3:    v = 24'd332050;
      5'd4:    v = 24'd166669;
      5'd5:    v = 24'd83416;
      5'd6:    v = 24'd41718;
      5'd7:    v = 24'd20860;
      5'd8:    v = 24'd10430;
      5'd9:    v = 24'd5215;
      5'd10:   v = 24'd2608;
      5'd11:   v = 24'd1304;
      5'd12:   v = 24'd652;
      5'd13:   v = 24'd326;
      5'd14:   v = 24'd163;
      5'd15:   v = 24'd81;
      5'd16:   v = 24'd41;
      5'd17:   v = 24'd20;
      5'd18:   v = 24'd10;
      5'd19:   v = 24'd5;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sincos_cordic_micro.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_micro_rotation
//  Purpose  : One combinational CORDIC rotation-mode step. Rotates (x, y)
//             by +/-atan(2^-i) toward driving the residual phase z to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module cordic_micro_rotation
  import sincos_cordic_pkg::*;
#(
  parameter int XW = 40
) (
  input  logic signed [XW-1:0]      i_x,
  input  logic signed [XW-1:0]      i_y,
  input  logic signed [PHASE_W-1:0] i_z,
  input  logic        [IDX_W-1:0]   i_idx,
  output logic signed [XW-1:0]      o_x,
  output logic signed [XW-1:0]      o_y,
  output logic signed [PHASE_W-1:0] o_z
);

  logic signed [XW-1:0]      w_x_sh;
  logic signed [XW-1:0]      w_y_sh;
  logic signed [PHASE_W-1:0] w_atan;
  logic                      w_d_pos;

  // z >= 0 rotates counter-clockwise (d = +1), otherwise clockwise
  assign w_d_pos = ~i_z[PHASE_W-1];
  assign w_x_sh  = i_x >>> i_idx;
  assign w_y_sh  = i_y >>> i_idx;
  assign w_atan  = $signed(atan_lut(i_idx));

  // Apply the shift-and-add rotation in the direction chosen by sign(z)
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (w_d_pos) begin
      o_x = i_x - w_y_sh;
      o_y = i_y + w_x_sh;
      o_z = i_z - w_atan;
    end else begin
      o_x = i_x + w_y_sh;
      o_y = i_y - w_x_sh;
      o_z = i_z + w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sincos_cordic.sv
`default_nettype none
// ============================================================================
//  Module   : sincos_cordic
//  Purpose  : Iterative CORDIC sine/cosine generator. The top two angle bits
//             select the quadrant; the remaining bits are rotated through
//             ITER micro-rotations, then rounded and quadrant-mapped.
//             Latency is ITER+2 clocks from start acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module sincos_cordic
  import sincos_cordic_pkg::*;
#(
  parameter int D_WIDTH     = 32,
  parameter int Q_BITS      = 10,
  parameter int ANGLE_WIDTH = 16,   // must not exceed PHASE_W
  parameter int ITER        = 16    // 8..20
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [ANGLE_WIDTH-1:0]    angle,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] sin,
  output logic signed [D_WIDTH-1:0] cos,
  output logic                      busy,
  output logic                      done
);

  // Internal x/y carry FRAC_EXT guard bits plus matching headroom
  localparam int XW = D_WIDTH + FRAC_EXT;

  localparam longint               C_X_INIT_L = longint'(CORDIC_GAIN * (2.0 ** (Q_BITS + FRAC_EXT)));
  localparam logic signed [XW-1:0] C_X_INIT   = XW'(C_X_INIT_L);
  localparam logic signed [XW-1:0] C_RND_HALF = XW'(1 << (FRAC_EXT - 1));
  localparam logic [IDX_W-1:0]     C_LAST_IT  = IDX_W'(ITER - 1);

  state_t                      r_state;
  logic [IDX_W-1:0]            r_iter;
  logic [1:0]                  r_quad;
  logic signed [XW-1:0]        r_x;
  logic signed [XW-1:0]        r_y;
  logic signed [PHASE_W-1:0]   r_z;
  logic signed [D_WIDTH-1:0]   r_sin;
  logic signed [D_WIDTH-1:0]   r_cos;
  logic                        r_busy;
  logic                        r_done;

  logic signed [PHASE_W-1:0]   w_z_init;
  logic signed [XW-1:0]        w_x_next;
  logic signed [XW-1:0]        w_y_next;
  logic signed [PHASE_W-1:0]   w_z_next;
  logic signed [XW-1:0]        w_x_sum;
  logic signed [XW-1:0]        w_y_sum;
  logic signed [D_WIDTH-1:0]   w_x_q;
  logic signed [D_WIDTH-1:0]   w_y_q;
  logic signed [D_WIDTH-1:0]   w_cos_map;
  logic signed [D_WIDTH-1:0]   w_sin_map;
  logic                        w_unused_lsbs;

  // In-quadrant residual scaled to 2^-24 turn units: always in [0, 2^22)
  assign w_z_init = PHASE_W'(angle[ANGLE_WIDTH-3:0]) << (PHASE_W - ANGLE_WIDTH);

  cordic_micro_rotation #(
    .XW (XW)
  ) u_micro (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_z   (r_z),
    .i_idx (r_iter),
    .o_x   (w_x_next),
    .o_y   (w_y_next),
    .o_z   (w_z_next)
  );

  // Round half-up, then drop the guard bits (arithmetic shift by FRAC_EXT)
  assign w_x_sum       = r_x + C_RND_HALF;
  assign w_y_sum       = r_y + C_RND_HALF;
  assign w_x_q         = w_x_sum[XW-1:FRAC_EXT];
  assign w_y_q         = w_y_sum[XW-1:FRAC_EXT];
  assign w_unused_lsbs = ^{w_x_sum[FRAC_EXT-1:0], w_y_sum[FRAC_EXT-1:0]};

  // Rotate the first-quadrant result into the quadrant of the request
  always_comb begin
    w_cos_map = w_x_q;
    w_sin_map = w_y_q;
    case (r_quad)
      2'd0: begin
        w_cos_map = w_x_q;
        w_sin_map = w_y_q;
      end
      2'd1: begin
        w_cos_map = -w_y_q;
        w_sin_map = w_x_q;
      end
      2'd2: begin
        w_cos_map = -w_x_q;
        w_sin_map = -w_y_q;
      end
      default: begin
        w_cos_map = w_y_q;
        w_sin_map = -w_x_q;
      end
    endcase
  end

  // Controller: accept in IDLE, iterate in ROTATE, publish in FINISH
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_quad  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_quad  <= angle[ANGLE_WIDTH-1:ANGLE_WIDTH-2];
            r_z     <= w_z_init;
            r_x     <= C_X_INIT;
            r_y     <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= ROTATE;
          end
        end
        ROTATE: begin
          r_x    <= w_x_next;
          r_y    <= w_y_next;
          r_z    <= w_z_next;
          r_iter <= r_iter + 1'b1;
          if (r_iter == C_LAST_IT) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_cos   <= w_cos_map;
          r_sin   <= w_sin_map;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sin  = r_sin;
  assign cos  = r_cos;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sincos_cordic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sincos_cordic
//  Purpose  : Self-checking bench for sincos_cordic against a real-valued
//             sine/cosine reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sincos_cordic;

  localparam int  D_WIDTH     = 32;
  localparam int  Q_BITS      = 10;
  localparam int  ANGLE_WIDTH = 16;
  localparam int  ITER        = 16;
  localparam int  ONE         = 1 << Q_BITS;
  localparam int  TOL         = 2;
  localparam int  LAT         = ITER + 1;   // edges after acceptance until done
  localparam int  TIMEOUT     = 40;
  localparam real PI          = 3.14159265358979323846;

  logic                      clk;
  logic                      rstb;
  logic [ANGLE_WIDTH-1:0]    angle;
  logic                      start;
  logic signed [D_WIDTH-1:0] dut_sin;
  logic signed [D_WIDTH-1:0] dut_cos;
  logic                      busy;
  logic                      done;

  int n_vec = 0;
  int n_err = 0;

  sincos_cordic #(
    .D_WIDTH     (D_WIDTH),
    .Q_BITS      (Q_BITS),
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ITER        (ITER)
  ) dut (
    .clk   (clk),
    .rstb  (rstb),
    .angle (angle),
    .start (start),
    .sin   (dut_sin),
    .cos   (dut_cos),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal rounded cos/sin of a one-turn-full-scale angle
  function automatic void ideal(input logic [ANGLE_WIDTH-1:0] a, output int c, output int s);
    real th;
    th = real'(a) * 2.0 * PI / real'(1 << ANGLE_WIDTH);
    c  = int'($floor($cos(th) * real'(ONE) + 0.5));
    s  = int'($floor($sin(th) * real'(ONE) + 0.5));
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Issue one request and wait (bounded) for done; angle is scrambled in flight
  task automatic run_one(input logic [ANGLE_WIDTH-1:0] a, output int k, output bit got);
    angle = a;
    start = 1'b1;
    step();
    start = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < TIMEOUT) begin
      angle = ANGLE_WIDTH'($urandom);
      step();
      k++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int  k;
    bit  got;
    int  ec, es;
    rstb  = 1'b1;
    start = 1'b1;
    angle = 16'h1234;
    #2 rstb = 1'b0;
    repeat (3) step();
    n_vec++; if (dut_sin !== 0) begin n_err++; $display("FAIL reset_sin: got %0d expected 0", dut_sin); end
    n_vec++; if (dut_cos !== 0) begin n_err++; $display("FAIL reset_cos: got %0d expected 0", dut_cos); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    // Release between edges; the very next edge must accept start
    #2 rstb = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_accept busy: got %b expected 1", busy); end
    k = 0; got = 1'b0;
    while (!got && k < TIMEOUT) begin
      step();
      k++;
      if (done) got = 1'b1;
    end
    ideal(16'h1234, ec, es);
    n_vec++; if (!got || k != LAT) begin n_err++; $display("FAIL reset_first_latency: got %0d (done=%b) expected %0d", k, got, LAT); end
    n_vec++; if (absd(dut_cos, ec) > TOL || absd(dut_sin, es) > TOL) begin
      n_err++; $display("FAIL reset_first_value: got cos=%0d sin=%0d expected %0d,%0d", dut_cos, dut_sin, ec, es);
    end
  endtask

  task automatic test_cardinal();
    logic [ANGLE_WIDTH-1:0] angs [5];
    int  exp_c [5];
    int  exp_s [5];
    int  k;
    bit  got;
    angs  = '{16'h0000, 16'h2000, 16'h4000, 16'h8000, 16'hC000};
    exp_c = '{1024, 724, 0, -1024, 0};
    exp_s = '{0, 724, 1024, 0, -1024};
    for (int n = 0; n < 5; n++) begin
      run_one(angs[n], k, got);
      n_vec++; if (!got || k != LAT) begin n_err++; $display("FAIL cardinal_latency %h: got %0d (done=%b) expected %0d", angs[n], k, got, LAT); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cardinal_busy_at_done %h: got %b expected 0", angs[n], busy); end
      n_vec++; if (absd(dut_cos, exp_c[n]) > TOL) begin n_err++; $display("FAIL cardinal_cos %h: got %0d expected %0d", angs[n], dut_cos, exp_c[n]); end
      n_vec++; if (absd(dut_sin, exp_s[n]) > TOL) begin n_err++; $display("FAIL cardinal_sin %h: got %0d expected %0d", angs[n], dut_sin, exp_s[n]); end
      repeat (3) step();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL cardinal_done_pulse %h: got %b expected 0", angs[n], done); end
      n_vec++; if (absd(dut_cos, exp_c[n]) > TOL || absd(dut_sin, exp_s[n]) > TOL) begin
        n_err++; $display("FAIL cardinal_hold %h: got cos=%0d sin=%0d expected %0d,%0d", angs[n], dut_cos, dut_sin, exp_c[n], exp_s[n]);
      end
    end
  endtask

  // start held high with a new angle every cycle: one result every ITER+2
  task automatic test_back_to_back();
    logic [ANGLE_WIDTH-1:0] a;
    int  k, ec, es;
    bit  got;
    start = 1'b1;
    for (int r = 0; r < 10; r++) begin
      a     = ANGLE_WIDTH'($urandom);
      angle = a;
      step();
      k = 0; got = 1'b0;
      while (!got && k < TIMEOUT) begin
        angle = ANGLE_WIDTH'($urandom);
        step();
        k++;
        if (done) got = 1'b1;
      end
      ideal(a, ec, es);
      n_vec++; if (!got || k != LAT) begin n_err++; $display("FAIL b2b_period r%0d: got %0d (done=%b) expected %0d", r, k, got, LAT); end
      n_vec++; if (absd(dut_cos, ec) > TOL || absd(dut_sin, es) > TOL) begin
        n_err++; $display("FAIL b2b_value %h: got cos=%0d sin=%0d expected %0d,%0d", a, dut_cos, dut_sin, ec, es);
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    int  k, ec, es, ndone;
    bit  got;
    logic [ANGLE_WIDTH-1:0] a;
    run_one(16'h1000, k, got);
    step();
    angle = ANGLE_WIDTH'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    #2 rstb = 1'b0;
    #1;
    n_vec++; if (dut_sin !== 0 || dut_cos !== 0) begin n_err++; $display("FAIL midreset_outputs: got cos=%0d sin=%0d expected 0,0", dut_cos, dut_sin); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0,0", busy, done); end
    step();
    #2 rstb = 1'b1;
    ndone = 0;
    repeat (30) begin
      step();
      if (done) ndone++;
    end
    n_vec++; if (ndone != 0) begin n_err++; $display("FAIL midreset_no_done: got %0d done pulses expected 0", ndone); end
    a = ANGLE_WIDTH'($urandom);
    run_one(a, k, got);
    ideal(a, ec, es);
    n_vec++; if (!got || k != LAT) begin n_err++; $display("FAIL midreset_recover_latency: got %0d (done=%b) expected %0d", k, got, LAT); end
    n_vec++; if (absd(dut_cos, ec) > TOL || absd(dut_sin, es) > TOL) begin
      n_err++; $display("FAIL midreset_recover_value %h: got cos=%0d sin=%0d expected %0d,%0d", a, dut_cos, dut_sin, ec, es);
    end
  endtask

  task automatic test_sweep();
    logic [ANGLE_WIDTH-1:0] a;
    int  k, ec, es, e, max_err, ndone;
    bit  got;
    max_err = 0;
    ndone   = 0;
    for (int p = 0; p < 4096; p++) begin
      a = ANGLE_WIDTH'(p * 16 + int'($urandom_range(0, 15)));
      run_one(a, k, got);
      if (got) ndone++;
      ideal(a, ec, es);
      e = absd(dut_cos, ec);
      if (absd(dut_sin, es) > e) e = absd(dut_sin, es);
      if (e > max_err) max_err = e;
      n_vec++; if (!got || e > TOL || absd(dut_cos, 0) > ONE + TOL || absd(dut_sin, 0) > ONE + TOL) begin
        n_err++; $display("FAIL sweep %h: got cos=%0d sin=%0d done=%b expected %0d,%0d", a, dut_cos, dut_sin, got, ec, es);
      end
    end
    n_vec++; if (ndone != 4096) begin n_err++; $display("FAIL sweep_done_count: got %0d expected 4096", ndone); end
    n_vec++; if (max_err > TOL) begin n_err++; $display("FAIL sweep_max_err: got %0d expected <= %0d", max_err, TOL); end
  endtask

  initial begin
    start = 1'b0;
    angle = '0;
    rstb  = 1'b1;
    test_reset();
    test_cardinal();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sincos_cordic.md
SINCOS_CORDIC -- requirements
Module: sincos_cordic

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: signed width of the sin/cos outputs.
REQ-002 SHALL have parameter Q_BITS, default 10: output fractional bits, so 1.0 = 2^Q_BITS = 1024.
REQ-003 SHALL have parameter ANGLE_WIDTH, default 16: unsigned angle; full scale = one turn (0x4000 = 90 deg).
REQ-004 SHALL have parameter ITER, default 16: CORDIC micro-rotations, range 8..20.
REQ-005 SHALL have one clock and one reset: clk input 1, the single clock; rstb input 1, asynchronous active-low reset.
REQ-006 SHALL have input angle, width ANGLE_WIDTH: electrical angle theta, sampled with start.
REQ-007 SHALL have input start, width 1: request pulse.
REQ-008 SHALL have output sin, signed D_WIDTH: sin(theta) in Q_BITS format, registered.
REQ-009 SHALL have output cos, signed D_WIDTH: cos(theta) in Q_BITS format, registered.
REQ-010 SHALL have output busy, width 1: high from start acceptance to the end of the FINISH state.
REQ-011 SHALL have output done, width 1: one-cycle pulse marking that sin/cos are new.

Function
REQ-012 SHALL use FSM states IDLE, ROTATE, FINISH.
REQ-013 SHALL accept start only in IDLE.
REQ-014 SHALL ignore start while busy, with no queuing.
REQ-015 SHALL, on the accepting edge t0, register the quadrant as angle[MSB:MSB-1].
REQ-016 SHALL, on edge t0, register the residual angle[MSB-2:0] left-aligned into a 24-bit phase register z (units 2^-24 turn).
REQ-017 SHALL, on edge t0, load x = round(0.6072529350 * 2^(Q_BITS+8)) and y = 0, then enter ROTATE with iteration counter i = 0.
REQ-018 SHALL, in ROTATE, perform one micro-rotation per edge using d = sign(z), treating z >= 0 as d = +1.
REQ-019 SHALL compute each micro-rotation as x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i], then increment i.
REQ-020 SHALL hold x and y internally with Q_BITS+8 fractional bits, signed width D_WIDTH+8, so no overflow can occur.
REQ-021 SHALL leave ROTATE for FINISH on the edge that completes iteration ITER-1 (edge t0+ITER).
REQ-022 SHALL, on edge t0+ITER+1 in FINISH, round x and y to Q_BITS by adding 2^7 and then arithmetic-shifting right by 8.
REQ-023 SHALL then map by quadrant: q0 (cos,sin) = (x,y); q1 = (-y,x); q2 = (-x,-y); q3 = (y,-x).
REQ-024 SHALL, on that same edge, register the mapped sin/cos, assert done and return to IDLE.
REQ-025 SHALL keep done high for exactly one cycle; total latency is ITER+2 edges from acceptance.
REQ-026 SHALL deassert busy in the cycle in which done is high.
REQ-027 SHALL accept a start that is high during the done cycle, giving back-to-back throughput of one result every ITER+2 cycles.
REQ-028 SHALL hold sin/cos stable between done pulses.
REQ-029 SHALL keep every error within +/-2 LSB of the ideal rounded value for ITER = 16 and Q_BITS = 10.
REQ-030 SHALL produce exact quadrant boundaries: angle 0x4000 gives cos within +/-2 and sin = 1024 +/-2, never exceeding +/-(2^Q_BITS + 2).
REQ-031 SHALL hold angle/start sampling: a change on angle after t0 SHALL not affect the result in flight.

Reset
REQ-032 SHALL, on rstb low, asynchronously force sin = 0, cos = 0, done = 0, busy = 0, state = IDLE, i = 0 and x/y/z/quadrant = 0.
REQ-033 SHALL, on reset asserted mid-ROTATE or mid-FINISH, abort the computation with no done pulse after release.
REQ-034 SHALL, after reset release, accept start on the first rising edge.

Structure
REQ-035 SHALL place the state enum, the ITER-entry ATAN table (atan(2^-i) in 2^-24 turn units, 20 entries) and the gain constant 0.6072529350 in package sincos_cordic_pkg.
REQ-036 SHALL implement one combinational sub-module, cordic_micro_rotation, that maps (x, y, z, i) to (x', y', z').
REQ-037 SHALL keep the FSM, counter and quadrant map in sincos_cordic.

Verification
REQ-038 SHALL cover: angle 0x0000, start -> after 18 cycles done = 1, cos = 1024 +/-2, sin = 0 +/-2.
REQ-039 SHALL cover: angle 0x2000 -> cos = 724 +/-2, sin = 724 +/-2.
REQ-040 SHALL cover: angle 0x4000, 0x8000, 0xC000 -> (cos,sin) = (0,1024), (-1024,0), (0,-1024), each +/-2.
REQ-041 SHALL cover: start held high with angle changing every cycle -> one done per 18 cycles, results matching the angle at each acceptance edge.
REQ-042 SHALL cover: rstb pulsed low at cycle 7 of a rotation -> sin = cos = 0, no done, next start completes normally.
REQ-043 SHALL cover: a 4096-point sweep against a real-valued model -> max error <= 2 LSB, done count 4096.
